keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl_pkg.sv | 37 +++
 rtl/keypad_scan_ctrl_if.sv | 19 +
 rtl/keypad_fifo.sv | 57 +++++
 rtl/keypad_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared definitions for the keypad scanner: register map, bit positions,
// scan FSM encoding and the row/column to keycode table.
package keypad_scan_ctrl_pkg;

    // Register addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_CNT_LSB   = 3;

    // CTRL bit positions
    localparam int CTRL_SCAN_EN_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;
    localparam int CTRL_CLR_OVF_BIT = 2;
    localparam int CTRL_FLUSH_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FRAME  = 2'd3
    } scan_state_t;

    // Entry i = row*4 + col holds the keycode; entry 0 sits in bits [3:0].
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] keycode(input logic [3:0] idx);
        return KEYMAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Host register bus of the keypad scanner. Handshake: a read is a single
// cycle with re=1; data_out is valid combinationally in that cycle and a DATA
// read pops on the closing edge. A write is a single cycle with we=1, taken on
// the closing edge. No back-pressure exists; the slave is always ready.
interface keypad_scan_ctrl_if;
    import keypad_scan_ctrl_pkg::*;

    logic [1:0]  addr;
    logic [7:0]  data_in;
    logic        we;
    logic        re;
    logic [7:0]  data_out;
    logic        irq;
    scan_state_t dbg_state;

    modport master (output addr, data_in, we, re, input data_out, irq, dbg_state);
    modport slave  (input addr, data_in, we, re, output data_out, irq, dbg_state);

endinterface

// File: rtl/keypad_fifo.sv
// Keycode queue: power-of-two depth, flush beats push/pop, a push while full
// only succeeds when a pop happens on the same edge.
module keypad_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_dout,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: drives one column low at a time, samples the synced
// rows, debounces whole frames and queues accepted keycodes for the host.
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         row,
    output logic [3:0]         col,
    keypad_scan_ctrl_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_MAX  = BW'(DEBOUNCE_FRAMES);

    scan_state_t r_state;
    logic [3:0]  r_row_s1, r_row_s2, r_col;
    logic [1:0]  r_col_idx;
    logic [DW-1:0] r_div;
    logic [15:0] r_frame;
    logic        r_prev_valid, r_acc_valid;
    logic [3:0]  r_prev_key, r_acc_key;
    logic [BW-1:0] r_stable;
    logic        r_scan_en, r_irq_en, r_ovf, r_irq;

    logic        w_wr_ctrl, w_flush, w_clr_ovf, w_pop, w_push;
    logic        w_cand_valid, w_same;
    logic [3:0]  w_cand_key, w_dout;
    logic [4:0]  w_nclosed;
    logic [BW-1:0] w_cnt_next;
    logic [CW:0] w_count;
    logic [2:0]  w_cnt_sat;
    logic        w_full, w_empty, w_unused;
    logic [7:0]  w_rd;

    assign w_wr_ctrl = bus.we && (bus.addr == ADDR_CTRL);
    assign w_flush   = w_wr_ctrl && bus.data_in[CTRL_FLUSH_BIT];
    assign w_clr_ovf = w_wr_ctrl && bus.data_in[CTRL_CLR_OVF_BIT];
    assign w_pop     = bus.re && (bus.addr == ADDR_DATA) && !w_empty;
    assign w_unused  = &{1'b0, bus.data_in[7:4]};

    // Two-flop synchronizer on the asynchronous row inputs (idle = released).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    // Frame decode: a candidate exists only when exactly one switch is closed.
    always_comb begin
        w_nclosed  = 5'd0;
        w_cand_key = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (r_frame[i]) begin
                w_nclosed  = w_nclosed + 5'd1;
                w_cand_key = keycode(4'(i));
            end
        end
        w_cand_valid = (w_nclosed == 5'd1);
        w_same       = (w_cand_valid == r_prev_valid) &&
                       (!w_cand_valid || (w_cand_key == r_prev_key));
        w_cnt_next   = !w_same ? BW'(1) : ((r_stable == DEB_MAX) ? DEB_MAX : r_stable + 1'b1);
        w_push       = (r_state == ST_FRAME) && r_scan_en && (w_cnt_next == DEB_MAX) &&
                       w_cand_valid && (!r_acc_valid || (r_acc_key != w_cand_key));
    end

    // Scan FSM with column drive, frame capture and debounce state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_col        <= 4'hF;
            r_col_idx    <= 2'd0;
            r_div        <= '0;
            r_frame      <= 16'h0000;
            r_prev_valid <= 1'b0;
            r_prev_key   <= 4'h0;
            r_stable     <= '0;
            r_acc_valid  <= 1'b0;
            r_acc_key    <= 4'h0;
        end else if ((r_state != ST_IDLE) && !r_scan_en) begin
            r_state      <= ST_IDLE;
            r_col        <= 4'hF;
            r_prev_valid <= 1'b0;
            r_stable     <= '0;
            r_acc_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_col <= 4'hF;
                    if (r_scan_en) begin
                        r_state   <= ST_DRIVE;
                        r_col_idx <= 2'd0;
                        r_div     <= '0;
                        r_col     <= 4'b1110;
                    end
                end
                ST_DRIVE: begin
                    if (r_div == DIV_LAST) r_state <= ST_SAMPLE;
                    else                   r_div   <= r_div + 1'b1;
                end
                ST_SAMPLE: begin
                    for (int r = 0; r < 4; r++) r_frame[{2'(r), r_col_idx}] <= ~r_row_s2[r];
                    if (r_col_idx != 2'd3) begin
                        r_col_idx <= r_col_idx + 2'd1;
                        r_col     <= ~(4'b0001 << (r_col_idx + 2'd1));
                        r_div     <= '0;
                        r_state   <= ST_DRIVE;
                    end else begin
                        r_state <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    r_prev_valid <= w_cand_valid;
                    r_prev_key   <= w_cand_key;
                    r_stable     <= w_cnt_next;
                    if (w_cnt_next == DEB_MAX) begin
                        r_acc_valid <= w_cand_valid;
                        r_acc_key   <= w_cand_key;
                    end
                    r_col_idx <= 2'd0;
                    r_col     <= 4'b1110;
                    r_div     <= '0;
                    r_state   <= ST_DRIVE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Control register, sticky overflow and registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_en <= 1'b0;
            r_irq_en  <= 1'b0;
            r_ovf     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_scan_en <= bus.data_in[CTRL_SCAN_EN_BIT];
                r_irq_en  <= bus.data_in[CTRL_IRQ_EN_BIT];
            end
            if (w_clr_ovf)                                    r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop && !w_flush)  r_ovf <= 1'b1;
            r_irq <= r_irq_en && !w_empty;
        end
    end

    keypad_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_cand_key),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_dout  (w_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_cnt_sat = (int'(w_count) > 7) ? 3'd7 : 3'(w_count);

    // Combinational read mux, quiet (0x00) whenever re is low.
    always_comb begin
        w_rd = 8'h00;
        if (bus.re) begin
            case (bus.addr)
                ADDR_DATA:   w_rd = w_empty ? 8'h00 : {1'b1, 3'b000, w_dout};
                ADDR_STATUS: w_rd = {2'b00, w_cnt_sat, r_ovf, w_full, w_empty};
                ADDR_CTRL:   w_rd = {6'b000000, r_irq_en, r_scan_en};
                default:     w_rd = 8'h00;
            endcase
        end
    end

    assign col           = r_col;
    assign bus.data_out  = w_rd;
    assign bus.irq       = r_irq;
    assign bus.dbg_state = r_state;

endmodule
